// File: rtl/level_round_player_if.sv
// Level/game interface between the level controller, the user keys and the
// round player. The player sits on the slave side; the driver of the inputs
// (level controller plus key logic) sits on the master side.
interface level_round_player_if;
    logic       levelupdated;
    logic [3:0] level_num;
    logic       rng_button;
    logic       user_valid;
    logic [1:0] user_key;
    logic [3:0] led_out;
    logic       busy;
    logic       win;
    logic       lose;
    logic [4:0] seq_len;

    modport master (
        output levelupdated, level_num, rng_button, user_valid, user_key,
        input  led_out, busy, win, lose, seq_len
    );

    modport slave (
        input  levelupdated, level_num, rng_button, user_valid, user_key,
        output led_out, busy, win, lose, seq_len
    );
endinterface

// File: rtl/level_round_player.sv
// Memory-round player: shows an LFSR-generated symbol sequence on 4 LEDs,
// then checks the user's key presses against the same sequence regenerated
// from the stored round seed. Emits a one-cycle win or lose pulse.
module level_round_player #(
    parameter int         MAX_LEN        = 16,
    parameter int         SHOW_CYCLES    = 50000000,
    parameter int         GAP_CYCLES     = 12500000,
    parameter int         TIMEOUT_CYCLES = 250000000,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic                 clock,
    input  logic                 rst,
    level_round_player_if.slave  lp
);

    // Timer must hold the largest of the three phase lengths.
    localparam int MAX_SG  = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int MAX_CNT = (MAX_SG > TIMEOUT_CYCLES) ? MAX_SG : TIMEOUT_CYCLES;
    localparam int TW      = $clog2(MAX_CNT + 1);

    localparam logic [TW-1:0] SHOW_LAST    = TW'(SHOW_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST     = TW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]    MAX_LEN_V    = 5'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SHOW_ON  = 3'd1,
        SHOW_OFF = 3'd2,
        WAIT_IN  = 3'd3,
        WIN      = 3'd4,
        LOSE     = 3'd5
    } state_t;

    // 8-bit Fibonacci LFSR step, taps 8,6,5,4.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    state_t        state_q, state_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [7:0]    seed_q, seed_d;
    logic [7:0]    pl_q, pl_d;
    logic [3:0]    level_q, level_d;
    logic [4:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]    seq_len_q, seq_len_d;
    logic [3:0]    led_q, led_d;
    logic          busy_q, busy_d;
    logic          win_q, win_d;
    logic          lose_q, lose_d;

    logic [3:0]    level_sel_s;
    logic [4:0]    len_raw_s;
    logic [4:0]    len_cap_s;
    logic [4:0]    idx_inc_s;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_next(lfsr_q);
        seed_d    = seed_q;
        pl_d      = pl_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        seq_len_d = seq_len_q;

        // A level strobe in the start cycle bypasses the stored level.
        if (lp.levelupdated) begin
            level_d     = lp.level_num;
            level_sel_s = lp.level_num;
        end else begin
            level_d     = level_q;
            level_sel_s = level_q;
        end
        len_raw_s = {1'b0, level_sel_s} + 5'd1;
        if (len_raw_s > MAX_LEN_V) begin
            len_cap_s = MAX_LEN_V;
        end else begin
            len_cap_s = len_raw_s;
        end
        idx_inc_s = idx_q + 5'd1;

        case (state_q)
            IDLE: begin
                if (lp.rng_button) begin
                    state_d   = SHOW_ON;
                    seq_len_d = len_cap_s;
                    seed_d    = lfsr_q;
                    pl_d      = lfsr_q;
                    idx_d     = 5'd0;
                    timer_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SHOW_ON: begin
                if (timer_q == SHOW_LAST) begin
                    state_d = SHOW_OFF;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SHOW_OFF: begin
                if (timer_q == GAP_LAST) begin
                    timer_d = '0;
                    if (idx_inc_s == seq_len_q) begin
                        // Rewind to the round seed so the check replays the sequence.
                        pl_d    = seed_q;
                        idx_d   = 5'd0;
                        state_d = WAIT_IN;
                    end else begin
                        pl_d    = lfsr_next(pl_q);
                        idx_d   = idx_inc_s;
                        state_d = SHOW_ON;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_IN: begin
                // A key in the timeout cycle takes priority over the timeout.
                if (lp.user_valid) begin
                    timer_d = '0;
                    if (lp.user_key == pl_q[1:0]) begin
                        pl_d  = lfsr_next(pl_q);
                        idx_d = idx_inc_s;
                        if (idx_inc_s == seq_len_q) begin
                            state_d = WIN;
                        end else begin
                            state_d = WAIT_IN;
                        end
                    end else begin
                        state_d = LOSE;
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = LOSE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WIN: begin
                state_d = IDLE;
            end
            LOSE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are derived from the next state so they line up with it.
        if (state_d == SHOW_ON) begin
            led_d = 4'b0001 << pl_d[1:0];
        end else begin
            led_d = 4'b0000;
        end
        busy_d = (state_d != IDLE);
        win_d  = (state_d == WIN);
        lose_d = (state_d == LOSE);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lfsr_q    <= LFSR_SEED;
            seed_q    <= LFSR_SEED;
            pl_q      <= 8'h00;
            level_q   <= 4'd0;
            idx_q     <= 5'd0;
            timer_q   <= '0;
            seq_len_q <= 5'd1;
            led_q     <= 4'b0000;
            busy_q    <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            seed_q    <= seed_d;
            pl_q      <= pl_d;
            level_q   <= level_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            seq_len_q <= seq_len_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            win_q     <= win_d;
            lose_q    <= lose_d;
        end
    end

    assign lp.led_out = led_q;
    assign lp.busy    = busy_q;
    assign lp.win     = win_q;
    assign lp.lose    = lose_q;
    assign lp.seq_len = seq_len_q;

endmodule

// File: tb/tb_level_round_player.sv
// Directed bench for level_round_player with short phase lengths and MAX_LEN=8.
module tb_level_round_player;

    logic clock = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    level_round_player_if lp ();

    level_round_player #(
        .MAX_LEN        (8),
        .SHOW_CYCLES    (4),
        .GAP_CYCLES     (2),
        .TIMEOUT_CYCLES (20),
        .LFSR_SEED      (8'hA5)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .lp    (lp)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] ref_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Reference LFSR: free-running from the reset seed.
    logic [7:0] m_lfsr;
    always @(posedge clock or posedge rst) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= ref_step(m_lfsr);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Plays one round from IDLE. wrong_at = key index to get wrong (-1: none).
    task automatic play_round(input int exp_len, input int wrong_at,
                              input bit no_keys, input bit upd_mid);
        logic [7:0] seed;
        logic [7:0] p;
        logic [3:0] one;
        logic [1:0] key;
        bit         lost;
        one  = 4'b0001;
        lost = 1'b0;
        @(negedge clock);
        seed = m_lfsr;
        lp.rng_button = 1'b1;
        @(negedge clock);
        lp.rng_button = 1'b0;
        check_eq("start_seq_len", 32'(lp.seq_len), 32'(exp_len));
        check_eq("start_busy", 32'(lp.busy), 32'd1);
        p = seed;
        for (int i = 0; i < exp_len; i++) begin
            for (int c = 0; c < 4; c++) begin
                check_eq("show_led", 32'(lp.led_out), 32'(one << p[1:0]));
                if (upd_mid && i == 0 && c == 0) begin
                    lp.levelupdated = 1'b1;
                    lp.level_num    = 4'd5;
                end else begin
                    lp.levelupdated = 1'b0;
                end
                @(negedge clock);
            end
            for (int c = 0; c < 2; c++) begin
                check_eq("gap_led", 32'(lp.led_out), 32'd0);
                // Stray key during the gap must be ignored.
                if (i == 0 && c == 0) begin
                    lp.user_valid = 1'b1;
                    lp.user_key   = p[1:0] ^ 2'd1;
                end else begin
                    lp.user_valid = 1'b0;
                end
                @(negedge clock);
            end
            p = ref_step(p);
        end
        check_eq("round_seq_len", 32'(lp.seq_len), 32'(exp_len));
        p = seed;
        if (no_keys) begin
            for (int t = 0; t < 20; t++) begin
                check_eq("wait_no_lose", 32'(lp.lose), 32'd0);
                @(negedge clock);
            end
            check_eq("timeout_lose", 32'(lp.lose), 32'd1);
            check_eq("timeout_win", 32'(lp.win), 32'd0);
        end else begin
            for (int k = 0; k < exp_len; k++) begin
                key = p[1:0];
                if (k == wrong_at) key = key ^ 2'd1;
                lp.user_valid = 1'b1;
                lp.user_key   = key;
                @(negedge clock);
                lp.user_valid = 1'b0;
                if (k == wrong_at) begin
                    check_eq("wrong_lose", 32'(lp.lose), 32'd1);
                    check_eq("wrong_win", 32'(lp.win), 32'd0);
                    lost = 1'b1;
                    break;
                end else if (k < exp_len - 1) begin
                    check_eq("key_no_win", 32'(lp.win), 32'd0);
                    check_eq("key_no_lose", 32'(lp.lose), 32'd0);
                end else begin
                    check_eq("last_key_win", 32'(lp.win), 32'd1);
                    check_eq("last_key_lose", 32'(lp.lose), 32'd0);
                    check_eq("win_busy", 32'(lp.busy), 32'd1);
                end
                p = ref_step(p);
            end
            if (wrong_at >= 0) check_eq("lost_flag", 32'(lost), 32'd1);
        end
        @(negedge clock);
        check_eq("end_win", 32'(lp.win), 32'd0);
        check_eq("end_lose", 32'(lp.lose), 32'd0);
        check_eq("end_busy", 32'(lp.busy), 32'd0);
        check_eq("end_led", 32'(lp.led_out), 32'd0);
    endtask

    initial begin
        rst             = 1'b1;
        lp.levelupdated = 1'b0;
        lp.level_num    = 4'd0;
        lp.rng_button   = 1'b0;
        lp.user_valid   = 1'b0;
        lp.user_key     = 2'd0;
        #12;
        rst = 1'b0;
        check_eq("rst_led", 32'(lp.led_out), 32'd0);
        check_eq("rst_busy", 32'(lp.busy), 32'd0);
        check_eq("rst_win", 32'(lp.win), 32'd0);
        check_eq("rst_lose", 32'(lp.lose), 32'd0);
        check_eq("rst_seq_len", 32'(lp.seq_len), 32'd1);
        check_eq("rst_lfsr", 32'(dut.lfsr_q), 32'h0A5);
        @(negedge clock);
        check_eq("lfsr_step1", 32'(dut.lfsr_q), 32'h04A);
        for (int i = 0; i < 10; i++) begin
            check_eq("idle_led", 32'(lp.led_out), 32'd0);
            check_eq("idle_busy", 32'(lp.busy), 32'd0);
            check_eq("idle_winlose", 32'({lp.win, lp.lose}), 32'd0);
            check_eq("idle_seq_len", 32'(lp.seq_len), 32'd1);
            check_eq("idle_lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));
            @(negedge clock);
        end

        // Level 2 -> three-symbol rounds.
        lp.levelupdated = 1'b1;
        lp.level_num    = 4'd2;
        @(negedge clock);
        lp.levelupdated = 1'b0;
        play_round(3, -1, 1'b0, 1'b0);
        play_round(3, 1, 1'b0, 1'b0);
        // Timeout round with a level change mid-round.
        play_round(3, -1, 1'b1, 1'b1);
        play_round(6, -1, 1'b0, 1'b0);

        // Level 15 bypassed in the start cycle, capped at MAX_LEN, then reset mid-show.
        @(negedge clock);
        lp.levelupdated = 1'b1;
        lp.level_num    = 4'd15;
        lp.rng_button   = 1'b1;
        @(negedge clock);
        lp.levelupdated = 1'b0;
        lp.rng_button   = 1'b0;
        check_eq("cap_seq_len", 32'(lp.seq_len), 32'd8);
        check_eq("cap_busy", 32'(lp.busy), 32'd1);
        @(negedge clock);
        #2;
        rst = 1'b1;
        #1;
        check_eq("abort_led", 32'(lp.led_out), 32'd0);
        check_eq("abort_busy", 32'(lp.busy), 32'd0);
        check_eq("abort_winlose", 32'({lp.win, lp.lose}), 32'd0);
        check_eq("abort_seq_len", 32'(lp.seq_len), 32'd1);
        check_eq("abort_lfsr", 32'(dut.lfsr_q), 32'h0A5);
        @(negedge clock);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_eq("post_rst_winlose", 32'({lp.win, lp.lose}), 32'd0);
            check_eq("post_rst_busy", 32'(lp.busy), 32'd0);
            check_eq("post_rst_lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
